// File: rtl/nibble_flag_packer_if.sv
// Serial flag-bit input and packed-nibble output handshakes of nibble_flag_packer.
interface nibble_flag_packer_if;
   logic       in_valid;
   logic       in_ready;
   logic       in_bit;
   logic       in_sof;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;

   modport master (
      output in_valid, in_bit, in_sof, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_bit, in_sof, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/nibble_flag_packer.sv
// Packs serial flag bits (first = MSB) into nibbles behind a small output FIFO.
// Optional saturating drop counter: define NIBBLE_PACKER_DROP_CNT_EN.
module nibble_flag_packer #(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   nibble_flag_packer_if.slave   bus
`ifdef NIBBLE_PACKER_DROP_CNT_EN
   ,
   output logic [7:0]            drop_cnt
`endif
);
   localparam int             PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);
   localparam logic [3:0]     FULL = 4'(DEPTH);

   logic [1:0]    cnt_q, cnt_d;
   logic [3:0]    part_q, part_d;
   logic [3:0]    mem_q [DEPTH];
   logic [3:0]    mem_d [DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [3:0]    count_q, count_d;
   logic          ov_q, ov_d;
   logic [3:0]    od_q, od_d;
   logic          acc, push, pop, full;

   assign full         = (count_q == FULL);
   assign bus.in_ready = (cnt_q != 2'd3) | ~full;
   assign acc          = bus.in_valid & bus.in_ready;
   assign push         = acc & ~bus.in_sof & (cnt_q == 2'd3);
   assign pop          = ov_q & bus.out_ready;

   assign bus.out_valid = ov_q;
   assign bus.out_data  = od_q;

   always_comb begin
      cnt_d  = cnt_q;
      part_d = part_q;
      if (acc) begin
         if (bus.in_sof) begin
            part_d[3] = bus.in_bit;
            cnt_d     = 2'd1;
         end else if (cnt_q == 2'd3) begin
            cnt_d = 2'd0;
         end else begin
            part_d[2'd3 - cnt_q] = bus.in_bit;
            cnt_d                = cnt_q + 2'd1;
         end
      end
   end

   // Output regs track the post-edge FIFO head so they stay registered.
   always_comb begin
      mem_d   = mem_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      if (push) begin
         mem_d[wp_q] = {part_q[3:1], bus.in_bit};
         wp_d        = (wp_q == LAST) ? '0 : wp_q + PW'(1);
      end
      if (pop) begin
         rp_d = (rp_q == LAST) ? '0 : rp_q + PW'(1);
      end
      count_d = count_q + {3'b000, push} - {3'b000, pop};
      ov_d    = (count_d != 4'd0);
      od_d    = ov_d ? mem_d[rp_d] : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= 2'd0;
         part_q  <= 4'b0000;
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= 4'd0;
         ov_q    <= 1'b0;
         od_q    <= 4'b0000;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'b0000;
      end else begin
         cnt_q   <= cnt_d;
         part_q  <= part_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

`ifdef NIBBLE_PACKER_DROP_CNT_EN
   logic       drop;
   logic [7:0] drop_q;

   assign drop     = acc & bus.in_sof & (cnt_q != 2'd0);
   assign drop_cnt = drop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= 8'h00;
      end else if (drop && drop_q != 8'hFF) begin
         drop_q <= drop_q + 8'd1;
      end
   end
`endif
endmodule

// File: tb/tb_nibble_flag_packer.sv
// Self-checking bench for nibble_flag_packer: vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_nibble_flag_packer;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nibble_flag_packer_if bus ();
`ifdef NIBBLE_PACKER_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   nibble_flag_packer #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef NIBBLE_PACKER_DROP_CNT_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   typedef struct {
      logic       v, b, s, r;
      logic       ir, ov;
      logic [3:0] od;
   } vec_t;

   vec_t vecs [22];

   int         total = 0;
   int         bad   = 0;
   int         bits_m [$];
   logic [3:0] fifo_m [$];
   int         drops = 0;
   logic [3:0] dut_last = 4'b0000;

   function automatic vec_t mk(logic v, logic b, logic s, logic r,
                               logic ir, logic ov, logic [3:0] od);
      vec_t t;
      t.v = v; t.b = b; t.s = s; t.r = r;
      t.ir = ir; t.ov = ov; t.od = od;
      return t;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic b, input logic s, input logic r);
      bus.in_valid  = v;
      bus.in_bit    = b;
      bus.in_sof    = s;
      bus.out_ready = r;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bits_m.delete();
      fifo_m.delete();
      drops = 0;
   endtask

   // One clock of traffic checked against the reference model.
   task automatic cycle(input logic v, input logic b, input logic s, input logic r);
      logic mr, mv, acc, pop;
      int   nib;
      drive(v, b, s, r);
      @(negedge clk);
      mr = !(bits_m.size() == 3 && fifo_m.size() == DEPTH);
      mv = (fifo_m.size() != 0);
      chk("in_ready", int'(bus.in_ready), int'(mr));
      chk("out_valid", int'(bus.out_valid), int'(mv));
      chk("out_data", int'(bus.out_data), mv ? int'(fifo_m[0]) : 0);
`ifdef NIBBLE_PACKER_DROP_CNT_EN
      chk("drop_cnt", int'(drop_cnt), (drops > 255) ? 255 : drops);
`endif
      acc = v & mr;
      pop = mv & r;
      if (pop) dut_last = bus.out_data;
      @(posedge clk);
      if (pop) void'(fifo_m.pop_front());
      if (acc) begin
         if (s) begin
            if (bits_m.size() != 0) drops++;
            bits_m.delete();
            bits_m.push_back(int'(b));
         end else begin
            bits_m.push_back(int'(b));
            if (bits_m.size() == 4) begin
               nib = bits_m[0] * 8 + bits_m[1] * 4 + bits_m[2] * 2 + bits_m[3];
               fifo_m.push_back(4'(nib));
               bits_m.delete();
            end
         end
      end
      #1;
   endtask

   initial begin
      vecs[0]  = mk(1, 0, 1, 1, 1, 0, 4'h0);
      vecs[1]  = mk(1, 1, 0, 1, 1, 0, 4'h0);
      vecs[2]  = mk(1, 0, 0, 1, 1, 0, 4'h0);
      vecs[3]  = mk(1, 1, 0, 1, 1, 0, 4'h0);
      vecs[4]  = mk(0, 0, 0, 1, 1, 1, 4'h5);
      vecs[5]  = mk(0, 0, 0, 1, 1, 0, 4'h0);
      vecs[6]  = mk(1, 1, 1, 0, 1, 0, 4'h0);
      vecs[7]  = mk(1, 0, 0, 0, 1, 0, 4'h0);
      vecs[8]  = mk(1, 1, 0, 0, 1, 0, 4'h0);
      vecs[9]  = mk(1, 0, 0, 0, 1, 0, 4'h0);
      vecs[10] = mk(1, 0, 0, 0, 1, 1, 4'hA);
      vecs[11] = mk(1, 1, 0, 0, 1, 1, 4'hA);
      vecs[12] = mk(1, 1, 0, 0, 1, 1, 4'hA);
      vecs[13] = mk(1, 0, 0, 0, 1, 1, 4'hA);
      vecs[14] = mk(1, 1, 0, 0, 1, 1, 4'hA);
      vecs[15] = mk(1, 1, 0, 0, 1, 1, 4'hA);
      vecs[16] = mk(1, 1, 0, 0, 1, 1, 4'hA);
      vecs[17] = mk(1, 1, 0, 0, 0, 1, 4'hA);
      vecs[18] = mk(1, 1, 0, 1, 0, 1, 4'hA);
      vecs[19] = mk(1, 1, 0, 1, 1, 1, 4'h6);
      vecs[20] = mk(0, 0, 0, 1, 1, 1, 4'hF);
      vecs[21] = mk(0, 0, 0, 1, 1, 0, 4'h0);

      drive(0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst in_ready", int'(bus.in_ready), 1);
      chk("rst out_valid", int'(bus.out_valid), 0);
      chk("rst out_data", int'(bus.out_data), 0);
`ifdef NIBBLE_PACKER_DROP_CNT_EN
      chk("rst drop_cnt", int'(drop_cnt), 0);
`endif

      for (int i = 0; i < 22; i++) begin
         drive(vecs[i].v, vecs[i].b, vecs[i].s, vecs[i].r);
         @(negedge clk);
         chk($sformatf("vec%0d in_ready", i), int'(bus.in_ready), int'(vecs[i].ir));
         chk($sformatf("vec%0d out_valid", i), int'(bus.out_valid), int'(vecs[i].ov));
         chk($sformatf("vec%0d out_data", i), int'(bus.out_data), int'(vecs[i].od));
         @(posedge clk);
         #1;
      end

      // sof mid-nibble resynchronises
      do_reset();
      cycle(1, 1, 0, 1);
      cycle(1, 1, 0, 1);
      cycle(1, 0, 1, 1);
      cycle(1, 0, 0, 1);
      cycle(1, 1, 0, 1);
      cycle(1, 1, 0, 1);
      repeat (3) cycle(0, 0, 0, 1);
      chk("sof nibble", int'(dut_last), 3);
`ifdef NIBBLE_PACKER_DROP_CNT_EN
      chk("sof drop_cnt", int'(drop_cnt), 1);
`endif

      // full FIFO with toggling out_ready
      do_reset();
      for (int i = 0; i < 12; i++) cycle(1, 1'($urandom), i == 0, 0);
      for (int i = 0; i < 80; i++) cycle(1, 1'($urandom), 0, 1'(i & 1));
      repeat (8) cycle(0, 0, 0, 1);

      // reset mid-nibble with a buffered entry
      do_reset();
      cycle(1, 1, 1, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 1, 0, 0);
      cycle(1, 1, 0, 0);
      cycle(1, 1, 0, 0);
      cycle(1, 0, 0, 0);
      do_reset();
      @(negedge clk);
      chk("mid rst out_valid", int'(bus.out_valid), 0);
      chk("mid rst out_data", int'(bus.out_data), 0);
      chk("mid rst in_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      cycle(1, 1, 0, 1);
      cycle(1, 0, 0, 1);
      cycle(1, 0, 0, 1);
      cycle(1, 0, 0, 1);
      repeat (2) cycle(0, 0, 0, 1);
      chk("post rst nibble", int'(dut_last), 8);
`ifdef NIBBLE_PACKER_DROP_CNT_EN
      chk("post rst drop_cnt", int'(drop_cnt), 0);
`endif

      // drop counter saturation
      do_reset();
      cycle(1, 1, 1, 1);
      repeat (300) cycle(1, 0, 1, 1);
      repeat (3) cycle(0, 0, 0, 1);
`ifdef NIBBLE_PACKER_DROP_CNT_EN
      chk("drop sat", int'(drop_cnt), 255);
`endif

      // randomized traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 3) != 0, 1'($urandom),
               $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
      end
      repeat (10) cycle(0, 0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/nibble_flag_packer.md
Name: nibble_flag_packer

Overview:
- Upstream feeder for the 4-flag packed-struct consumer, whose fields are first, second, third and fourth, with first as the MSB.
- Accepts a serial stream of flag bits under valid/ready and assembles each group of 4 into one 4-bit word in field order.
- Completed words are buffered in a small output FIFO and presented to the consumer under valid/ready.
- A start-of-frame marker resynchronises nibble alignment.

Parameters:
DEPTH, 2, output FIFO depth in nibbles (legal range 1..8)

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  serial bit valid
in_ready  output  1  packer can accept a bit
in_bit  input  1  serial flag bit
in_sof  input  1  qualifies in_bit as field first of a new nibble
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_data  output  4  packed nibble: [3]=first, [2]=second, [1]=third, [0]=fourth
drop_cnt  output  8  present only with NIBBLE_PACKER_DROP_CNT_EN

Behaviour:
- Reset is synchronous and active-high on clk (rst=1 at a rising edge). Reset state:
  - cnt=0, partial=0, FIFO empty;
  - out_valid=0, out_data=4'b0000, in_ready=1, drop_cnt=0.
- Reset asserted mid-nibble or with a non-empty FIFO discards everything. It does not count as a drop.
- Bit accept condition: acc = in_valid & in_ready.
- Collector state is cnt (0..3), tracking the field index of the next bit. Transitions on acc:
  - in_sof=1: bit goes to partial[3]; cnt becomes 1. A drop event occurs if the old cnt was not 0.
  - in_sof=0 and cnt<3: bit goes to partial[3-cnt]; cnt increments.
  - in_sof=0 and cnt=3: {partial[3:1], in_bit} is pushed to the FIFO; cnt becomes 0.
- in_sof is ignored when acc=0.
- An in_sof bit at cnt=0 is a normal first bit, not a drop.
- in_ready = (cnt != 3) | ~fifo_full.
  - in_ready does not depend on in_valid, in_sof or out_ready. There is no combinational ready path.
  - Consequence: with cnt=3 and the FIFO full, every bit (including in_sof) stalls until a pop frees space.
- FIFO pop occurs on out_valid & out_ready.
  - Push and pop in the same cycle are legal whenever the FIFO is not full.
  - Occupancy is unchanged in that case.
- out_valid = FIFO not empty. out_data = head entry when out_valid=1, else 4'b0000.
- out_data and out_valid are registered outputs.
- Latency: 4th bit accepted at edge N into an empty FIFO gives out_valid=1 with the new data after edge N, i.e. visible in cycle N+1.
- Throughput: one bit per cycle sustained when out_ready=1, giving one nibble per 4 cycles.
- FIFO pointers wrap modulo DEPTH. Full means count==DEPTH; empty means count==0.
- Order preservation: nibbles leave in push order; none are lost or duplicated.
- out_valid stays high and out_data stays stable until the pop while out_ready=0.

Optional Feature:
- Macro: NIBBLE_PACKER_DROP_CNT_EN.
- When defined:
  - port drop_cnt[7:0] exists;
  - it increments by 1 on every drop event (acc & in_sof & cnt!=0);
  - it saturates at 8'hFF;
  - it is cleared only by rst.
- When undefined: the port and its counter are absent; drop events discard silently. All other behaviour is identical.

Test Plan:
1. After reset, out_ready=1; send bits 0,1,0,1 (sof on the first) on consecutive cycles -> out_valid for 1 cycle at N+1 with out_data=4'b0101 (first=0, second=1, third=0, fourth=1); in_ready stays 1 throughout.
2. out_ready=0, DEPTH=2; stream 12 bits 1010_0110_1111 -> two nibbles buffered, in_ready=0 at cnt=3. Raise out_ready -> pops 4'b1010 then 4'b0110, the stalled bit is accepted, and 4'b1111 follows.
3. Send bits 1,1 then sof with bit 0, then 0,1,1 -> single nibble 4'b0011. drop_cnt=1 when the macro is defined.
4. Full FIFO with out_ready toggling 1/0 every cycle during a continuous stream -> no loss or duplication; output sequence equals input nibbles in order.
5. Assert rst with cnt=2 and the FIFO holding 1 entry -> next cycle out_valid=0, out_data=0, in_ready=1. The subsequent bits 1,0,0,0 give 4'b1000; drop_cnt=0.
6. With the macro defined, force 300 sof-mid-nibble events -> drop_cnt saturates and holds at 8'hFF.
